// File: rtl/cpe_pkg.sv
// cpe_pkg: shared constants, kernel FSM states and width helper for the CPE blocks
package cpe_pkg;
  localparam int KERNEL_SIZE = 3;
  localparam int WIDTH = 16;
  localparam int PSUM_LAT = 5;
  typedef enum logic [2:0] {IDLE, LOAD, RUN, DRAIN, DONE} kstate_t;
  function automatic int clog2(input int v);
    int r;
    r = 1;
    while ((1 << r) < v) r++;
    return r;
  endfunction
endpackage

// File: rtl/cpe_valid_delay.sv
// cpe_valid_delay: window-valid bit delayed DEPTH mult_run-qualified edges, pulsed only on advancing cycles
module cpe_valid_delay #(
  parameter int DEPTH = cpe_pkg::PSUM_LAT
) (
  input  logic clock,
  input  logic reset,
  input  logic adv,
  input  logic valid_in,
  output logic valid_out
);
  logic [DEPTH-2:0] sr;
  // the output register is the last stage, so it only holds a result on an advancing cycle
  always_ff @(posedge clock) begin
    if (reset) begin
      sr <= '0;
      valid_out <= 1'b0;
    end else begin
      if (adv) sr <= (sr << 1) | (DEPTH-1)'(valid_in);
      valid_out <= adv & sr[DEPTH-2];
    end
  end
endmodule

// File: rtl/cpe_kernel_feeder.sv
// cpe_kernel_feeder: loads one kernel into the multiplier, then runs one row of windows plus pipeline drain
module cpe_kernel_feeder #(
  parameter int KERNEL_SIZE = cpe_pkg::KERNEL_SIZE,
  parameter int WIDTH = cpe_pkg::WIDTH,
  parameter int PSUM_LAT = cpe_pkg::PSUM_LAT,
  parameter int CNT_W = 16
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             start,
  input  logic [CNT_W-1:0] num_windows,
  input  logic             w_valid,
  input  logic [WIDTH-1:0] w_data,
  output logic             w_ready,
  output logic             kernel_run,
  output logic [WIDTH-1:0] kernel_input,
  output logic             mult_run,
  output logic             pix_adv,
  output logic             psum_valid,
  output logic             busy,
  output logic             done
);
  import cpe_pkg::*;
  localparam int K2 = KERNEL_SIZE * KERNEL_SIZE;
  localparam int LW = clog2(K2);
  localparam int DW = clog2(PSUM_LAT);
  kstate_t state, state_n;
  logic [CNT_W-1:0] n_lat, run_cnt;
  logic [LW-1:0] load_cnt;
  logic [DW-1:0] drain_cnt;
  logic hs, accept, last_w, last_run, last_drain;
  assign w_ready = state == LOAD;
  assign hs = w_valid & w_ready;
  // busy still covers the done cycle, which keeps a start there from being taken
  assign accept = start & (state == IDLE) & ~busy;
  assign last_w = load_cnt == LW'(K2 - 1);
  assign last_run = run_cnt == n_lat - CNT_W'(1);
  assign last_drain = drain_cnt == DW'(PSUM_LAT - 2);
  always_ff @(posedge clock) begin
    if (reset) state <= IDLE;
    else state <= state_n;
  end
  always_comb begin
    state_n = state;
    case (state)
      IDLE: state_n = accept ? LOAD : IDLE;
      LOAD: state_n = (hs & last_w) ? ((n_lat == '0) ? DONE : RUN) : LOAD;
      RUN: state_n = last_run ? DRAIN : RUN;
      DRAIN: state_n = last_drain ? DONE : DRAIN;
      DONE: state_n = IDLE;
      default: state_n = IDLE;
    endcase
  end
  // run outputs lag their state by one edge, so mult_run begins after the last kernel shift
  always_ff @(posedge clock) begin
    if (reset) begin
      n_lat <= '0;
      run_cnt <= '0;
      load_cnt <= '0;
      drain_cnt <= '0;
      kernel_run <= 1'b0;
      kernel_input <= '0;
      mult_run <= 1'b0;
      pix_adv <= 1'b0;
      busy <= 1'b0;
      done <= 1'b0;
    end else begin
      if (accept) n_lat <= num_windows;
      load_cnt <= (state == LOAD) ? load_cnt + LW'(hs) : '0;
      run_cnt <= (state == RUN) ? run_cnt + CNT_W'(1) : '0;
      drain_cnt <= (state == DRAIN) ? drain_cnt + DW'(1) : '0;
      kernel_run <= hs;
      if (hs) kernel_input <= w_data;
      mult_run <= (state == RUN) | (state == DRAIN);
      pix_adv <= state == RUN;
      busy <= (state_n != IDLE) | (state == DONE);
      done <= state == DONE;
    end
  end
  cpe_valid_delay #(.DEPTH(PSUM_LAT)) u_valid_delay (
    .clock(clock),
    .reset(reset),
    .adv(mult_run),
    .valid_in(pix_adv),
    .valid_out(psum_valid)
  );
endmodule

// File: tb/tb_cpe_kernel_feeder.sv
// tb_cpe_kernel_feeder: directed per-scenario checks of load, run, drain and psum_valid timing
module tb_cpe_kernel_feeder;
  localparam int LEN = 48;
  logic clock = 1'b0;
  logic reset, start, w_valid;
  logic [15:0] num_windows, w_data;
  logic w_ready, kernel_run, mult_run, pix_adv, psum_valid, busy, done;
  logic [15:0] kernel_input;
  logic [LEN-1:0] kr_v, mr_v, pa_v, pv_v, dn_v, by_v, wr_v;
  logic [15:0] ki [0:LEN-1];
  logic [15:0] kq [0:LEN-1];
  int nk, pass_cnt, total_cnt;

  cpe_kernel_feeder dut (
    .clock(clock), .reset(reset), .start(start), .num_windows(num_windows),
    .w_valid(w_valid), .w_data(w_data), .w_ready(w_ready),
    .kernel_run(kernel_run), .kernel_input(kernel_input), .mult_run(mult_run),
    .pix_adv(pix_adv), .psum_valid(psum_valid), .busy(busy), .done(done)
  );

  always #5 clock = ~clock;

  function automatic logic [LEN-1:0] mask(input int lo, input int hi);
    logic [LEN-1:0] m;
    for (int i = 0; i < LEN; i++) m[i] = (i >= lo) && (i <= hi);
    return m;
  endfunction

  task automatic sample(input int t);
    kr_v[t] = kernel_run; mr_v[t] = mult_run; pa_v[t] = pix_adv; pv_v[t] = psum_valid;
    dn_v[t] = done; by_v[t] = busy; wr_v[t] = w_ready; ki[t] = kernel_input;
  endtask

  // cycle 0 carries start; the weight pattern offers data every (gap+1) cycles from cycle 1
  task automatic run_job(input int n, input int gap, input bit noise, input int rst_at,
                         input logic [15:0] base, input int stp, input bit extra);
    int wi;
    wi = 0;
    sample(0);
    start = 1'b1; num_windows = 16'(n); w_valid = 1'b0;
    for (int t = 1; t < LEN; t++) begin
      @(posedge clock); #1;
      start = 1'b0; reset = 1'b0;
      sample(t);
      if (noise && t == 2) num_windows = 16'd7;
      if (noise && (t == 3 || t == 12 || t == 18)) start = 1'b1;
      if (t == rst_at) reset = 1'b1;
      w_valid = (wi < 9 && ((t - 1) % (gap + 1)) == 0) || (extra && wi >= 9);
      w_data = (wi < 9) ? base + 16'(wi * stp) : 16'hDEAD;
      if (w_valid && w_ready) wi++;
    end
    w_valid = 1'b0;
    nk = 0;
    for (int t = 0; t < LEN; t++) if (kr_v[t] === 1'b1) begin kq[nk] = ki[t]; nk++; end
  endtask

  task automatic test_reset;
    reset = 1'b1; start = 1'b0; w_valid = 1'b0; w_data = 16'h1234; num_windows = 16'd3;
    repeat (3) @(posedge clock);
    #1;
    total_cnt++;
    if ({w_ready, kernel_run, mult_run, pix_adv, psum_valid, busy, done} !== 7'b0)
      $display("FAIL reset_outs got %b exp 0", {w_ready, kernel_run, mult_run, pix_adv, psum_valid, busy, done});
    else pass_cnt++;
    total_cnt++;
    if (kernel_input !== 16'd0) $display("FAIL reset_kin got %h exp 0", kernel_input); else pass_cnt++;
    reset = 1'b0;
    @(posedge clock); #1;
  endtask

  task automatic test_back_to_back;
    run_job(4, 0, 1'b0, -1, 16'd1, 1, 1'b1);
    total_cnt++; if (kr_v !== mask(2, 10)) $display("FAIL b2b kernel_run got %h exp %h", kr_v, mask(2, 10)); else pass_cnt++;
    for (int i = 0; i < 9; i++) begin
      total_cnt++; if (kq[i] !== 16'(i + 1)) $display("FAIL b2b kin[%0d] got %0d exp %0d", i, kq[i], i + 1); else pass_cnt++;
    end
    total_cnt++; if (ki[30] !== 16'd9) $display("FAIL b2b kin_hold got %h exp 9", ki[30]); else pass_cnt++;
    total_cnt++; if (wr_v !== mask(1, 9)) $display("FAIL b2b w_ready got %h exp %h", wr_v, mask(1, 9)); else pass_cnt++;
    total_cnt++; if (mr_v !== mask(11, 18)) $display("FAIL b2b mult_run got %h exp %h", mr_v, mask(11, 18)); else pass_cnt++;
    total_cnt++; if (pa_v !== mask(11, 14)) $display("FAIL b2b pix_adv got %h exp %h", pa_v, mask(11, 14)); else pass_cnt++;
    total_cnt++; if (pv_v !== mask(16, 19)) $display("FAIL b2b psum_valid got %h exp %h", pv_v, mask(16, 19)); else pass_cnt++;
    total_cnt++; if (dn_v !== mask(19, 19)) $display("FAIL b2b done got %h exp %h", dn_v, mask(19, 19)); else pass_cnt++;
    total_cnt++; if (by_v !== mask(1, 19)) $display("FAIL b2b busy got %h exp %h", by_v, mask(1, 19)); else pass_cnt++;
  endtask

  task automatic test_bubbles;
    logic [LEN-1:0] exp_kr;
    exp_kr = '0;
    for (int i = 0; i < 9; i++) exp_kr[2 + 3 * i] = 1'b1;
    run_job(2, 2, 1'b0, -1, 16'd100, 7, 1'b0);
    total_cnt++; if (kr_v !== exp_kr) $display("FAIL bub kernel_run got %h exp %h", kr_v, exp_kr); else pass_cnt++;
    for (int i = 0; i < 9; i++) begin
      total_cnt++; if (kq[i] !== 16'(100 + 7 * i)) $display("FAIL bub kin[%0d] got %0d exp %0d", i, kq[i], 100 + 7 * i); else pass_cnt++;
    end
    total_cnt++; if (mr_v !== mask(27, 32)) $display("FAIL bub mult_run got %h exp %h", mr_v, mask(27, 32)); else pass_cnt++;
    total_cnt++; if (pa_v !== mask(27, 28)) $display("FAIL bub pix_adv got %h exp %h", pa_v, mask(27, 28)); else pass_cnt++;
    total_cnt++; if (pv_v !== mask(32, 33)) $display("FAIL bub psum_valid got %h exp %h", pv_v, mask(32, 33)); else pass_cnt++;
    total_cnt++; if (dn_v !== mask(33, 33)) $display("FAIL bub done got %h exp %h", dn_v, mask(33, 33)); else pass_cnt++;
  endtask

  task automatic test_one_window;
    run_job(1, 0, 1'b0, -1, 16'd1, 1, 1'b0);
    total_cnt++; if (mr_v !== mask(11, 15)) $display("FAIL n1 mult_run got %h exp %h", mr_v, mask(11, 15)); else pass_cnt++;
    total_cnt++; if (pa_v !== mask(11, 11)) $display("FAIL n1 pix_adv got %h exp %h", pa_v, mask(11, 11)); else pass_cnt++;
    total_cnt++; if (pv_v !== mask(16, 16)) $display("FAIL n1 psum_valid got %h exp %h", pv_v, mask(16, 16)); else pass_cnt++;
    total_cnt++; if (dn_v !== mask(16, 16)) $display("FAIL n1 done got %h exp %h", dn_v, mask(16, 16)); else pass_cnt++;
  endtask

  task automatic test_zero_windows;
    run_job(0, 0, 1'b0, -1, 16'd1, 1, 1'b0);
    total_cnt++; if (kr_v !== mask(2, 10)) $display("FAIL n0 kernel_run got %h exp %h", kr_v, mask(2, 10)); else pass_cnt++;
    total_cnt++; if ((mr_v | pa_v | pv_v) !== '0) $display("FAIL n0 run_outs got %h exp 0", mr_v | pa_v | pv_v); else pass_cnt++;
    total_cnt++; if (dn_v !== mask(11, 11)) $display("FAIL n0 done got %h exp %h", dn_v, mask(11, 11)); else pass_cnt++;
    total_cnt++; if (by_v !== mask(1, 11)) $display("FAIL n0 busy got %h exp %h", by_v, mask(1, 11)); else pass_cnt++;
  endtask

  task automatic test_ignored_start;
    run_job(3, 0, 1'b1, -1, 16'd1, 1, 1'b0);
    total_cnt++; if (kr_v !== mask(2, 10)) $display("FAIL ign kernel_run got %h exp %h", kr_v, mask(2, 10)); else pass_cnt++;
    total_cnt++; if (mr_v !== mask(11, 17)) $display("FAIL ign mult_run got %h exp %h", mr_v, mask(11, 17)); else pass_cnt++;
    total_cnt++; if (pv_v !== mask(16, 18)) $display("FAIL ign psum_valid got %h exp %h", pv_v, mask(16, 18)); else pass_cnt++;
    total_cnt++; if (dn_v !== mask(18, 18)) $display("FAIL ign done got %h exp %h", dn_v, mask(18, 18)); else pass_cnt++;
    total_cnt++; if (by_v !== mask(1, 18)) $display("FAIL ign busy got %h exp %h", by_v, mask(1, 18)); else pass_cnt++;
    total_cnt++; if (wr_v !== mask(1, 9)) $display("FAIL ign w_ready got %h exp %h", wr_v, mask(1, 9)); else pass_cnt++;
  endtask

  task automatic test_reset_mid_run;
    run_job(4, 0, 1'b0, 12, 16'd1, 1, 1'b0);
    total_cnt++; if (mr_v !== mask(11, 12)) $display("FAIL rst mult_run got %h exp %h", mr_v, mask(11, 12)); else pass_cnt++;
    total_cnt++; if (pa_v !== mask(11, 12)) $display("FAIL rst pix_adv got %h exp %h", pa_v, mask(11, 12)); else pass_cnt++;
    total_cnt++; if ((pv_v | dn_v) !== '0) $display("FAIL rst psum_done got %h exp 0", pv_v | dn_v); else pass_cnt++;
    total_cnt++; if (by_v !== mask(1, 12)) $display("FAIL rst busy got %h exp %h", by_v, mask(1, 12)); else pass_cnt++;
    total_cnt++; if (ki[13] !== 16'd0) $display("FAIL rst kin got %h exp 0", ki[13]); else pass_cnt++;
    run_job(2, 0, 1'b0, -1, 16'd1, 1, 1'b0);
    total_cnt++; if (mr_v !== mask(11, 16)) $display("FAIL rst2 mult_run got %h exp %h", mr_v, mask(11, 16)); else pass_cnt++;
    total_cnt++; if (pv_v !== mask(16, 17)) $display("FAIL rst2 psum_valid got %h exp %h", pv_v, mask(16, 17)); else pass_cnt++;
    total_cnt++; if (dn_v !== mask(17, 17)) $display("FAIL rst2 done got %h exp %h", dn_v, mask(17, 17)); else pass_cnt++;
  endtask

  initial begin
    pass_cnt = 0;
    total_cnt = 0;
    test_reset;
    test_back_to_back;
    test_bubbles;
    test_one_window;
    test_zero_windows;
    test_ignored_start;
    test_reset_mid_run;
    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end
endmodule

// File: doc/cpe_kernel_feeder.md
Name: cpe_kernel_feeder

Overview:
- Upstream driver of the CPE multiplier interface.
- Accepts KERNEL_SIZE*KERNEL_SIZE weights from the global weight buffer over valid/ready and replays them on kernel_run/kernel_input, exactly one shift per accepted weight.
- Then sequences mult_run for one row of windows plus pipeline drain, and flags the cycles in which psum_kernel carries a valid window result.
- Also advances the pixel register chain in lock-step with the windows.

Parameters:
- KERNEL_SIZE, 3: kernel edge length; weights per kernel K2 = KERNEL_SIZE*KERNEL_SIZE.
- WIDTH, 16: weight width.
- PSUM_LAT, 5: mult_run-qualified edges from window capture to psum_kernel update (product, inter0-3, inter4-5, inter6, psum).
- CNT_W, 16: width of window counter.

Ports:
- clock  in  1  single clock, rising edge.
- reset  in  1  synchronous, active-high reset.
- start  in  1  one-cycle request to process one kernel/row.
- num_windows  in  CNT_W  windows in the row; sampled on accepted start.
- w_valid  in  1  weight buffer data valid.
- w_data  in  WIDTH  weight.
- w_ready  out  1  feeder accepts weight.
- kernel_run  out  1  to multiplier; shift kernel register this edge.
- kernel_input  out  WIDTH  to multiplier; weight to shift in.
- mult_run  out  1  to multiplier; advance product/adder pipeline.
- pix_adv  out  1  to reg_chain; present next window.
- psum_valid  out  1  psum_kernel holds a valid window result this cycle.
- busy  out  1  high in every state except IDLE.
- done  out  1  one-cycle pulse at end of job.

Behaviour:
- Reset values: all outputs 0; kernel_input 0; FSM in IDLE; counters 0. Reset asserted in any state aborts the job; outputs are 0 after the next edge. No partial done is issued.
- All outputs are registered except w_ready, which is a decode of state LOAD.
- FSM transitions:
  - IDLE: start -> LOAD; latch num_windows; load_cnt = 0. start outside IDLE is ignored.
  - LOAD: w_ready = 1. On each handshake (w_valid & w_ready), next cycle kernel_run = 1 and kernel_input = w_data; otherwise kernel_run = 0 and kernel_input holds its value.
  - LOAD: weights are forwarded in arrival order, unmodified, no reordering. Bubbles on w_valid stall loading without extra shifts. Exactly K2 kernel_run pulses are issued per job.
  - LOAD exit: after the K2-th handshake, go to RUN, or to DONE if num_windows == 0. w_ready drops the cycle after the K2-th handshake.
  - RUN: starts the cycle after the last kernel_run pulse, so kernel_run and mult_run are never high together. mult_run = 1 and pix_adv = 1 for num_windows cycles (run_cnt 0..N-1), then -> DRAIN.
  - DRAIN: mult_run = 1, pix_adv = 0 for PSUM_LAT-1 cycles, then -> DONE. Total mult_run high cycles = N + PSUM_LAT - 1, contiguous.
  - DONE: done = 1 for one cycle, busy = 0 from the following cycle; -> IDLE. A start in the DONE cycle is ignored.
- psum_valid:
  - Let c = index of mult_run-high cycles, counting from 0.
  - psum_valid is high in cycle c+1 for c in [PSUM_LAT-1, N+PSUM_LAT-2]: exactly N contiguous cycles.
  - The last psum_valid cycle coincides with the DONE cycle.
  - N = 0: no mult_run, no pix_adv, no psum_valid; done follows the K2-th kernel_run by one cycle.
- Counters:
  - run_cnt compares against N-1, so N = 2^CNT_W - 1 is supported without wrap.
  - The drain counter is ceil(log2(PSUM_LAT)) bits wide.
- The feeder never drops a weight. Extra w_valid after the K2-th handshake is not accepted (w_ready = 0).

Decomposition:
- Shared package cpe_pkg:
  - Kernel FSM state enum {IDLE, LOAD, RUN, DRAIN, DONE}.
  - Constants KERNEL_SIZE, WIDTH, PSUM_LAT (shared with multiplier and reg_chain).
  - Function clog2 for counter widths.
- One natural sub-module: cpe_valid_delay, a PSUM_LAT-deep shift register of a window-valid bit. It advances only when mult_run = 1 and produces psum_valid. It can be reused by later accumulator stages.

Test Plan:
- 9 weights 1..9 back-to-back, N = 4 -> kernel_run high 9 consecutive cycles with kernel_input 1..9 in order; mult_run high 8 cycles; pix_adv high first 4; psum_valid high 4 cycles starting 5 cycles after mult_run rises; done coincides with the last psum_valid.
- Weights with w_valid bubbles (pattern 1,0,0,1,...) -> kernel_run pulses exactly on the cycle after each handshake, 9 total; no shift during bubbles; RUN starts only after the 9th.
- N = 1 -> mult_run high 5 cycles, pix_adv 1 cycle, psum_valid exactly 1 cycle; done same cycle.
- N = 0 -> 9 kernel_run pulses, then done next cycle; mult_run, pix_adv and psum_valid never high.
- start pulsed during LOAD and RUN -> ignored; num_windows changes mid-job have no effect; busy high from cycle after start through the done cycle.
- reset asserted on the 3rd RUN cycle -> all outputs 0 next cycle, no done; a new start with N = 2 then completes normally with 2 psum_valid cycles.
